// File: rtl/rom_msg_uart_tx_if.sv
// Signal bundle between rom_msg_uart_tx, its message ROM and the UART line.
// Also carries the FSM state for observation.
interface rom_msg_uart_tx_if #(
  parameter int ADDR_W = 4
);
  // start is a level request with no ready return. It is sampled only while idle,
  // and any assertion while busy is dropped. rom_data must be valid for rom_address
  // in the same cycle.
  logic              start;
  logic [ADDR_W-1:0] rom_address;
  logic [7:0]        rom_data;
  logic              tx;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  modport master (
    output start,
    output rom_data,
    input  rom_address,
    input  tx,
    input  busy,
    input  done,
    input  dbg_state
  );

  modport slave (
    input  start,
    input  rom_data,
    output rom_address,
    output tx,
    output busy,
    output done,
    output dbg_state
  );
endinterface

// File: rtl/rom_msg_uart_tx.sv
// Walks a 16x8 message ROM from address 0 and sends each byte as an 8N1 UART frame.
// Stops after MSG_LEN bytes or at the first NUL byte, then pulses done for one cycle.
module rom_msg_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int MSG_LEN      = 15,
  parameter int ADDR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  rom_msg_uart_tx_if.slave bus
);

  localparam int                BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]     BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // Every output is a flop. tx is loaded with the level of the state being entered,
  // so the line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        if (bus.rom_data == 8'h00) begin
          state_d = S_IDLE;
          addr_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_START;
          shreg_d = bus.rom_data;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[1];
          end
        end
      end
      S_STOP: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        tx_d   = 1'b1;
        if (baud_end) begin
          if (addr_q == ADDR_LAST) begin
            state_d = S_IDLE;
            addr_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rom_address = addr_q;
  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.dbg_state   = state_q;

endmodule
